// File: rtl/rv32i_pkg.sv
// Shared rv32i decode definitions: opcodes, ALU op encoding, immediate builders
// and the ID/EX pipeline register layout.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    alu_op_t     alu_op;
    logic        alu_alt;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
    logic [31:0] store_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
  } idex_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: sync reset, sync write, two combinational reads.
// x0 is hardwired to zero; optional same-cycle write-to-read bypass.
module regfile #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (BYPASS_EN && we && (waddr == raddr1)) rdata1 = wdata;
    if (BYPASS_EN && we && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/idstage.sv
// rv32i decode stage: one instruction per cycle into ID/EX, 1-cycle latency.
// Backpressure: ready_o drops on stall_i, load-use hazard or reset; ID/EX holds on stall.
module idstage
  import rv32i_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        instr_valid_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        valid_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_alt_op_o,
  output logic [31:0] operand1_o,
  output logic [31:0] operand2_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_branch_o,
  output logic        illegal_o,
  output logic [31:0] store_data_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val;
  logic        uses_rs1, uses_rs2, hazard;
  idex_t       dec, idex;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign rd     = instr_i[11:7];

  regfile #(.BYPASS_EN(BYPASS_EN)) u_regfile (
    .clk    (clk_i),
    .rst    (rst_i),
    .we     (wb_we_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    dec = '0;
    if (instr_i[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      dec.funct3 = funct3;
      unique case (opcode)
        OPC_OP: begin
          dec.operand1  = rs1_val;
          dec.operand2  = rs2_val;
          dec.alu_op    = alu_op_t'(funct3);
          dec.alu_alt   = instr_i[30];
          dec.rd        = rd;
          dec.reg_write = 1'b1;
        end
        OPC_OP_IMM: begin
          dec.operand1  = rs1_val;
          dec.imm       = imm_i(instr_i);
          // Shift immediates carry funct7 in the upper bits; only shamt is an operand.
          dec.operand2  = (funct3 == 3'b001 || funct3 == 3'b101) ?
                          {27'b0, instr_i[24:20]} : imm_i(instr_i);
          dec.alu_op    = alu_op_t'(funct3);
          dec.alu_alt   = (funct3 == 3'b101) && instr_i[30];
          dec.rd        = rd;
          dec.reg_write = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.operand1  = (opcode == OPC_AUIPC) ? pc_i : 32'd0;
          dec.operand2  = imm_u(instr_i);
          dec.imm       = imm_u(instr_i);
          dec.rd        = rd;
          dec.reg_write = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          dec.operand1  = pc_i;
          dec.operand2  = 32'd4;
          dec.imm       = (opcode == OPC_JAL) ? imm_j(instr_i) : imm_i(instr_i);
          dec.rd        = rd;
          dec.reg_write = 1'b1;
        end
        OPC_LOAD: begin
          dec.operand1  = rs1_val;
          dec.operand2  = imm_i(instr_i);
          dec.imm       = imm_i(instr_i);
          dec.rd        = rd;
          dec.reg_write = 1'b1;
          dec.is_load   = 1'b1;
        end
        OPC_STORE: begin
          dec.operand1   = rs1_val;
          dec.operand2   = imm_s(instr_i);
          dec.imm        = imm_s(instr_i);
          dec.store_data = rs2_val;
          dec.is_store   = 1'b1;
        end
        OPC_BRANCH: begin
          dec.operand1  = rs1_val;
          dec.operand2  = rs2_val;
          dec.alu_alt   = 1'b1;
          dec.imm       = imm_b(instr_i);
          dec.is_branch = 1'b1;
        end
        OPC_FENCE, OPC_SYSTEM: ;
        default: begin
          dec = '0;
          dec.illegal = 1'b1;
        end
      endcase
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    dec.valid = 1'b1;
    if (!instr_valid_i) dec = '0;
  end

  always_comb begin
    uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    uses_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    hazard   = idex.valid && idex.is_load && (idex.rd != 5'd0) && instr_valid_i &&
               ((uses_rs1 && (rs1 == idex.rd)) || (uses_rs2 && (rs2 == idex.rd)));
  end

  assign ready_o = !stall_i && !hazard && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)        idex <= '0;
    else if (flush_i) idex <= '0;
    else if (stall_i) idex <= idex;
    else if (hazard)  idex <= '0;
    else              idex <= dec;
  end

  assign valid_o      = idex.valid;
  assign alu_op_o     = idex.alu_op;
  assign alu_alt_op_o = idex.alu_alt;
  assign operand1_o   = idex.operand1;
  assign operand2_o   = idex.operand2;
  assign rd_o         = idex.rd;
  assign reg_write_o  = idex.reg_write;
  assign is_load_o    = idex.is_load;
  assign is_store_o   = idex.is_store;
  assign is_branch_o  = idex.is_branch;
  assign illegal_o    = idex.illegal;
  assign store_data_o = idex.store_data;
  assign imm_o        = idex.imm;
  assign funct3_o     = idex.funct3;

endmodule
